// File: rtl/fir_shift_add_param.sv
// Multiplier-free FIR: each tap is right-shifted by a programmable amount and summed.
// The sum is clipped to OW bits, and a sticky flag records any clipping.
module fir_shift_add_param #(
    parameter int DW   = 8,
    parameter int TAPS = 5,
    parameter int SW   = 3,
    parameter int OW   = 10,
    localparam int AW  = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] x,
    input  logic          flush,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [SW-1:0] cfg_shift,
    input  logic          cfg_en,
    output logic          out_valid,
    output logic [OW-1:0] dataout,
    output logic          sat
);

    localparam int SUMW = DW + $clog2(TAPS);
    localparam logic [SUMW-1:0] MAXOUT = SUMW'((64'd1 << OW) - 64'd1);

    logic [DW-1:0]   d_reg     [1:TAPS-1];
    logic [SW-1:0]   shift_reg [TAPS];
    logic            en_reg    [TAPS];
    logic [DW-1:0]   tap       [TAPS];
    logic [SUMW-1:0] term      [TAPS];
    logic [SUMW-1:0] sum_next;
    logic [OW-1:0]   clip_next;
    logic            out_valid_reg;
    logic [OW-1:0]   dataout_reg;
    logic            sat_reg;

    assign tap[0] = x;

    genvar gi;
    generate
        for (gi = 1; gi < TAPS; gi++) begin : g_tap
            assign tap[gi] = d_reg[gi];
        end
        // Shifts of DW or more would empty the tap, so they are forced to zero explicitly.
        for (gi = 0; gi < TAPS; gi++) begin : g_term
            assign term[gi] = (en_reg[gi] && (int'(shift_reg[gi]) < DW))
                              ? SUMW'(tap[gi] >> shift_reg[gi]) : '0;
        end
    endgenerate

    always_comb begin
        sum_next = '0;
        for (int k = 0; k < TAPS; k++) begin
            sum_next = sum_next + term[k];
        end
        clip_next = (sum_next > MAXOUT) ? OW'(MAXOUT) : sum_next[OW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int k = 1; k < TAPS; k++) begin
                d_reg[k] <= '0;
            end
        end else if (in_valid) begin
            for (int k = 1; k < TAPS; k++) begin
                d_reg[k] <= tap[k-1];
            end
        end
    end

    // Coefficient writes land after this edge, so a coincident sample sees the old set.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                shift_reg[k] <= SW'(TAPS - k);
                en_reg[k]    <= 1'b1;
            end
        end else if (cfg_we) begin
            for (int k = 0; k < TAPS; k++) begin
                if (int'(cfg_addr) == k) begin
                    shift_reg[k] <= cfg_shift;
                    en_reg[k]    <= cfg_en;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            dataout_reg   <= '0;
            sat_reg       <= 1'b0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (in_valid) begin
            out_valid_reg <= 1'b1;
            dataout_reg   <= clip_next;
            if (sum_next > MAXOUT) begin
                sat_reg <= 1'b1;
            end
        end else begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign dataout   = dataout_reg;
    assign sat       = sat_reg;

endmodule

// File: tb/tb_fir_shift_add_param.sv
// Directed and randomized bench for fir_shift_add_param against an arithmetic reference filter.
module tb_fir_shift_add_param;

    localparam int DW   = 8;
    localparam int TAPS = 5;
    localparam int SW   = 3;
    localparam int OW   = 10;
    localparam int AW   = 3;
    localparam int MAXO = (1 << OW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] x = '0;
    logic          flush = 1'b0;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [SW-1:0] cfg_shift = '0;
    logic          cfg_en = 1'b0;
    logic          out_valid;
    logic [OW-1:0] dataout;
    logic          sat;

    fir_shift_add_param #(.DW(DW), .TAPS(TAPS), .SW(SW), .OW(OW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .flush(flush),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_shift(cfg_shift), .cfg_en(cfg_en),
        .out_valid(out_valid), .dataout(dataout), .sat(sat)
    );

    always #5 clk = ~clk;

    // Reference state: history of accepted samples (newest first) and coefficient tables.
    int hist [TAPS-1];
    int mshift [TAPS];
    int men [TAPS];
    int mout, mvalid, msat;
    int n_checks = 0;
    int n_fail   = 0;
    int txn      = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_sum(input int xv);
        int s = 0;
        for (int k = 0; k < TAPS; k++) begin
            int v = (k == 0) ? xv : hist[k-1];
            if (men[k] != 0 && mshift[k] < DW) s += v / (1 << mshift[k]);
        end
        return s;
    endfunction

    // One clock cycle: apply inputs, advance the model, then compare all outputs.
    task automatic step(input int rs, input int iv, input int xv, input int fl,
                        input int we, input int addr, input int sh, input int en);
        int s;
        rst = rs[0]; in_valid = iv[0]; x = DW'(xv); flush = fl[0];
        cfg_we = we[0]; cfg_addr = AW'(addr); cfg_shift = SW'(sh); cfg_en = en[0];
        if (rs != 0) begin
            foreach (hist[k]) hist[k] = 0;
            for (int k = 0; k < TAPS; k++) begin mshift[k] = TAPS - k; men[k] = 1; end
            mout = 0; mvalid = 0; msat = 0;
        end else begin
            if (fl != 0) begin
                foreach (hist[k]) hist[k] = 0;
                mvalid = 0;
            end else if (iv != 0) begin
                s = model_sum(xv);
                mout = (s > MAXO) ? MAXO : s;
                if (s > MAXO) msat = 1;
                mvalid = 1;
                for (int k = TAPS - 2; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = xv;
            end else begin
                mvalid = 0;
            end
            if (we != 0 && addr < TAPS) begin
                mshift[addr] = sh;
                men[addr] = en;
            end
        end
        @(posedge clk);
        #1;
        txn++;
        $display("txn %0d rst=%0d iv=%0d x=%0d fl=%0d we=%0d -> out_valid=%0d dataout=%0d sat=%0d",
                 txn, rs, iv, xv, fl, we, out_valid, dataout, sat);
        check("out_valid", 32'(out_valid), 32'(mvalid));
        check("dataout", 32'(dataout), 32'(mout));
        check("sat", 32'(sat), 32'(msat));
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic sample(input int xv);
        step(0, 1, xv, 0, 0, 0, 0, 0);
    endtask

    int imp_tab  [6] = '{7, 15, 31, 63, 127, 0};
    int step_tab [8] = '{4, 12, 28, 60, 124, 124, 124, 124};
    int sat_tab  [5] = '{255, 510, 765, 1020, 1023};
    int dis_tab  [5] = '{7, 15, 31, 63, 0};

    initial begin
        // Reset state
        do_reset();
        do_reset();
        check("reset_dataout", 32'(dataout), 32'd0);

        // Impulse response with default shifts
        for (int i = 0; i < 6; i++) begin
            sample(i == 0 ? 255 : 0);
            check("impulse_tab", 32'(dataout), 32'(imp_tab[i]));
        end

        // Step response
        do_reset();
        for (int i = 0; i < 8; i++) begin
            sample(128);
            check("step_tab", 32'(dataout), 32'(step_tab[i]));
        end
        check("step_sat", 32'(sat), 32'd0);

        // Saturation with all shifts zero; sat is sticky
        do_reset();
        for (int k = 0; k < TAPS; k++) step(0, 0, 0, 0, 1, k, 0, 1);
        for (int i = 0; i < 5; i++) begin
            sample(255);
            check("sat_tab", 32'(dataout), 32'(sat_tab[i]));
            check("sat_flag", 32'(sat), (i == 4) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 6; i++) sample(0);
        check("sat_sticky", 32'(sat), 32'd1);

        // Gapped impulse: outputs only on accepted cycles, dataout held in gaps
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(0, (i % 2 == 0) ? 1 : 0, (i == 0) ? 255 : 0, 0, 0, 0, 0, 0);
            if (i % 2 == 0) check("gap_tab", 32'(dataout), 32'(imp_tab[i/2]));
            else check("gap_invalid", 32'(out_valid), 32'd0);
        end

        // Tap 4 disabled, then a flush clearing history mid-stream
        do_reset();
        step(0, 0, 0, 0, 1, 4, 1, 0);
        for (int i = 0; i < 5; i++) begin
            sample(i == 0 ? 255 : 0);
            check("disable_tab", 32'(dataout), 32'(dis_tab[i]));
        end
        sample(200);
        sample(100);
        step(0, 1, 50, 1, 0, 0, 0, 0);
        check("flush_invalid", 32'(out_valid), 32'd0);
        sample(0);
        check("flush_zero_hist", 32'(dataout), 32'd0);
        sample(64);
        check("flush_after", 32'(dataout), 32'd2);

        // Out-of-range address ignored; cfg write coinciding with a sample
        do_reset();
        step(0, 0, 0, 0, 1, 6, 0, 0);
        step(0, 1, 255, 0, 1, 0, 0, 1);
        check("cfg_pre_write", 32'(dataout), 32'd7);
        sample(255);
        check("cfg_post_write", 32'(dataout), 32'd270);

        // Mid-stream reset during step input
        do_reset();
        for (int i = 0; i < 3; i++) sample(128);
        step(1, 1, 128, 0, 0, 0, 0, 0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_dataout", 32'(dataout), 32'd0);
        for (int i = 0; i < 8; i++) begin
            sample(128);
            check("restart_tab", 32'(dataout), 32'(step_tab[i]));
        end

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int rs = ($urandom_range(0, 99) == 0) ? 1 : 0;
            int fl = ($urandom_range(0, 15) == 0) ? 1 : 0;
            int we = ($urandom_range(0, 5) == 0) ? 1 : 0;
            step(rs, $urandom_range(0, 3) != 0 ? 1 : 0, $urandom_range(0, 255), fl,
                 we, $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 3) != 0 ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_shift_add_param.md
FIR_SHIFT_ADD_PARAM -- requirements
Module: fir_shift_add_param

Interface
REQ-001 SHALL expose parameter DW, default 8, input sample width (unsigned).
REQ-002 SHALL expose parameter TAPS, default 5, number of taps (2..16).
REQ-003 SHALL expose parameter SW, default 3, per-tap shift-amount width.
REQ-004 SHALL expose parameter OW, default 10, output width (DW <= OW <= DW+clog2(TAPS)).
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  1  sample strobe; x accepted in cycles where high.
REQ-008 x  input  DW  input sample.
REQ-009 flush  input  1  clears delay line; coefficients kept.
REQ-010 cfg_we  input  1  coefficient write strobe.
REQ-011 cfg_addr  input  clog2(TAPS)  tap index to write.
REQ-012 cfg_shift  input  SW  right-shift amount for addressed tap.
REQ-013 cfg_en  input  1  tap enable for addressed tap (0 = tap contributes 0).
REQ-014 out_valid  output  1  dataout valid strobe.
REQ-015 dataout  output  OW  filtered sample, registered.
REQ-016 sat  output  1  sticky saturation flag.

Function
REQ-017 SHALL hold a delay line d[1..TAPS-1] of DW bits; tap 0 = current x.
REQ-018 On in_valid=1: d[1]<=x, d[k]<=d[k-1] for k>=2; on in_valid=0 delay line holds.
REQ-019 Per accepted sample, full sum S = sum over enabled k of (tap[k] >> shift[k]), tap[0]=x, tap[k]=d[k] pre-update; S width DW+clog2(TAPS), no truncation.
REQ-020 Shift amount >= DW SHALL yield 0 for that tap.
REQ-021 dataout SHALL register min(S, 2^OW-1) one cycle after in_valid; out_valid high exactly that cycle, else low.
REQ-022 dataout SHALL hold last value while out_valid=0.
REQ-023 sat SHALL set when S > 2^OW-1 on an accepted sample; cleared only by rst.
REQ-024 cfg_we=1 SHALL write shift[cfg_addr]<=cfg_shift, en[cfg_addr]<=cfg_en; cfg_addr >= TAPS ignored.
REQ-025 cfg write and in_valid same cycle: that sample uses pre-write coefficients; new values apply from next sample.
REQ-026 flush=1 SHALL zero d[1..TAPS-1] and force out_valid=0 next cycle; flush dominates in_valid (sample discarded); dataout, sat, coefficients unchanged.
REQ-027 Implementation SHALL be shift-and-add only, no multipliers.

Reset
REQ-028 rst=1 SHALL clear delay line, dataout=0, out_valid=0, sat=0 at next edge.
REQ-029 rst SHALL load shift[k]=TAPS-k (defaults 5,4,3,2,1) and en[k]=1 for all k.
REQ-030 rst SHALL dominate flush, cfg_we, in_valid; mid-stream reset discards in-flight sample (no out_valid after reset edge).

Verification (DW=8, TAPS=5, OW=10, defaults unless stated)
REQ-031 Impulse: x=255 one cycle then 0 each cycle, in_valid=1 -> dataout 7,15,31,63,127,0; out_valid each cycle.
REQ-032 Step: x=128 constant -> dataout 4,12,28,60,124,124...; sat=0.
REQ-033 Saturation: write shift=0 all taps, x=255 constant -> dataout 255,510,765,1020,1023; sat=1 from 5th output, stays 1 after x=0.
REQ-034 Gapped input: impulse 255 with in_valid toggling 1,0,1,0... -> same sequence 7,15,31,63,127 on valid cycles only; out_valid low in gaps.
REQ-035 Disable/flush: cfg_en=0 tap 4 + impulse 255 -> 7,15,31,63,0; flush after second sample -> next valid outputs reflect zeroed history.
REQ-036 Mid-stream rst during step input -> outputs 0/out_valid=0, shifts restored to 5,4,3,2,1, restart reproduces REQ-032.
